// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered ARM execute stage.
// Builds Val2, runs the ALU against a persistent NZCV register, computes the
// branch target and registers the result into the EX/MEM boundary.
// Optional feature macro: EXE_MUL_EN compiles in the iterative shift-add
// multiplier (MUL command) and its S_MUL state.
//
// state  | meaning
// S_IDLE | accepting instructions
// S_MUL  | shift-add multiply in flight, upstream held off (EXE_MUL_EN only)
module exe_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int OFS_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exe_cmd,
  input  logic              s_en,
  input  logic              imm_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              wb_en,
  input  logic              branch_en,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [11:0]       shift_operand,
  input  logic [OFS_W-1:0]  branch_ofs,
  input  logic [3:0]        dest,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] store_data,
  output logic [3:0]        dest_out,
  output logic              mem_r_out,
  output logic              mem_w_out,
  output logic              wb_out,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic              ill_cmd
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

`ifdef EXE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic              is_mem, is_mul, accept, start_mul, cmd_ok;
  logic [DATA_W-1:0] imm_ext, val2, op_b, alu_val, branch_target;
  logic [DATA_W:0]   sum;
  logic [3:0]        eff_cmd, nzcv_new;
  logic              cin, alu_c, alu_v;
  logic [OFS_W+1:0]  ofs_bytes;
  int                rot_n, sh_n, ror_n;

  logic              mul_busy, mul_done, mul_wb, mul_s;
  logic [DATA_W-1:0] mul_prod;
  logic [3:0]        mul_dest;

  assign is_mem    = mem_r_en | mem_w_en;
  assign is_mul    = MUL_EN && !is_mem && (exe_cmd == CMD_MUL);
  assign in_ready  = !mul_busy && !mem_stall && !flush;
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && is_mul;

  assign imm_ext       = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
  assign ofs_bytes     = {branch_ofs, 2'b00};
  assign branch_target = pc + DATA_W'($signed(ofs_bytes));

  // Val2: memory offset, rotated 8-bit immediate, or shifted register.
  always_comb begin
    rot_n = (2 * 32'(shift_operand[11:8])) % DATA_W;
    sh_n  = 32'(shift_operand[11:7]);
    ror_n = sh_n % DATA_W;
    val2  = val_rm;
    if (is_mem) begin
      val2 = {{(DATA_W-12){1'b0}}, shift_operand};
    end else if (imm_en) begin
      val2 = (imm_ext >> rot_n) | (imm_ext << (DATA_W - rot_n));
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2 = val_rm << sh_n;
        2'b01:   val2 = val_rm >> sh_n;
        2'b10:   val2 = $signed(val_rm) >>> sh_n;
        default: val2 = (val_rm >> ror_n) | (val_rm << (DATA_W - ror_n));
      endcase
    end
  end

  // ALU: one shared adder covers add/sub; logical ops carry C and V through.
  always_comb begin
    eff_cmd = is_mem ? CMD_ADD : exe_cmd;
    op_b    = val2;
    cin     = 1'b0;
    case (eff_cmd)
      CMD_ADC: cin = status[1];
      CMD_SUB: begin op_b = ~val2; cin = 1'b1;      end
      CMD_SBC: begin op_b = ~val2; cin = status[1]; end
      default: ;
    endcase
    sum     = {1'b0, val_rn} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
    alu_val = '0;
    alu_c   = status[1];
    alu_v   = status[0];
    cmd_ok  = 1'b1;
    case (eff_cmd)
      CMD_MOV: alu_val = val2;
      CMD_MVN: alu_val = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_val = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (val_rn[DATA_W-1] == op_b[DATA_W-1]) &&
                  (sum[DATA_W-1] != val_rn[DATA_W-1]);
      end
      CMD_AND: alu_val = val_rn & val2;
      CMD_ORR: alu_val = val_rn | val2;
      CMD_EOR: alu_val = val_rn ^ val2;
      CMD_MUL: cmd_ok  = MUL_EN;
      default: cmd_ok  = 1'b0;
    endcase
  end

  assign nzcv_new = {alu_val[DATA_W-1], alu_val == '0, alu_c, alu_v};

  // EX/MEM register and NZCV: flush, then multiply completion, then stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      alu_res      <= '0;
      store_data   <= '0;
      dest_out     <= '0;
      mem_r_out    <= 1'b0;
      mem_w_out    <= 1'b0;
      wb_out       <= 1'b0;
      branch_taken <= 1'b0;
      branch_addr  <= '0;
      status       <= '0;
      ill_cmd      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ill_cmd   <= 1'b0;
    end else if (mul_done) begin
      out_valid    <= 1'b1;
      alu_res      <= mul_prod;
      dest_out     <= mul_dest;
      wb_out       <= mul_wb;
      mem_r_out    <= 1'b0;
      mem_w_out    <= 1'b0;
      branch_taken <= 1'b0;
      ill_cmd      <= 1'b0;
      if (mul_s) status[3:2] <= {mul_prod[DATA_W-1], mul_prod == '0};
    end else if (mem_stall) begin
      // hold everything
    end else if (start_mul) begin
      out_valid <= 1'b0;
      ill_cmd   <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      alu_res      <= alu_val;
      store_data   <= val_rm;
      dest_out     <= dest;
      mem_r_out    <= mem_r_en;
      mem_w_out    <= mem_w_en;
      wb_out       <= wb_en && cmd_ok;
      branch_taken <= branch_en;
      branch_addr  <= branch_target;
      ill_cmd      <= !cmd_ok;
      if (s_en && cmd_ok && !is_mem) status <= nzcv_new;
    end else begin
      out_valid <= 1'b0;
      ill_cmd   <= 1'b0;
    end
  end

`ifdef EXE_MUL_EN
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_step;
  logic [CNT_W-1:0]  count_q;
  logic [3:0]        mul_dest_q;
  logic              mul_wb_q, mul_s_q;

  // State register; reset drops a multiply in flight without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Completion fires on the last iteration, or later once a stall releases.
  always_comb begin
    state_d  = state_q;
    mul_done = 1'b0;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_prod = (count_q != '0) ? acc_step : acc_q;
    case (state_q)
      S_IDLE: if (start_mul) state_d = S_MUL;
      S_MUL: begin
        if ((count_q <= CNT_W'(1)) && !mem_stall) begin
          mul_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      mul_done = 1'b0;
    end
  end

  // Shift-add datapath; keeps iterating through a stall until count hits 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      mul_dest_q <= '0;
      mul_wb_q   <= 1'b0;
      mul_s_q    <= 1'b0;
    end else if (start_mul) begin
      mcand_q    <= val_rn;
      mplier_q   <= val_rm;
      acc_q      <= '0;
      count_q    <= CNT_W'(DATA_W);
      mul_dest_q <= dest;
      mul_wb_q   <= wb_en;
      mul_s_q    <= s_en;
    end else if (state_q == S_MUL && count_q != '0) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CNT_W'(1);
    end
  end

  assign mul_busy = (state_q == S_MUL);
  assign mul_dest = mul_dest_q;
  assign mul_wb   = mul_wb_q;
  assign mul_s    = mul_s_q;
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign mul_dest = '0;
  assign mul_wb   = 1'b0;
  assign mul_s    = 1'b0;
`endif

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe (DATA_W=32, OFS_W=24).
// Exercises the MUL path when EXE_MUL_EN is defined, otherwise checks that
// 1010 is rejected as an unsupported command.
module tb_exe_stage_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  exe_cmd;
  logic        s_en, imm_en, mem_r_en, mem_w_en, wb_en, branch_en;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] branch_ofs;
  logic [3:0]  dest;
  logic        mem_stall, flush;
  logic        out_valid;
  logic [31:0] alu_res, store_data, branch_addr;
  logic [3:0]  dest_out, status;
  logic        mem_r_out, mem_w_out, wb_out, branch_taken, ill_cmd;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  exe_stage_pipe #(.DATA_W(32), .OFS_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .s_en(s_en), .imm_en(imm_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .wb_en(wb_en), .branch_en(branch_en), .pc(pc),
    .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
    .branch_ofs(branch_ofs), .dest(dest), .mem_stall(mem_stall), .flush(flush),
    .out_valid(out_valid), .alu_res(alu_res), .store_data(store_data),
    .dest_out(dest_out), .mem_r_out(mem_r_out), .mem_w_out(mem_w_out),
    .wb_out(wb_out), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status(status), .ill_cmd(ill_cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] sop, input logic imm, input logic s);
    in_valid      = 1'b1;
    exe_cmd       = cmd;
    val_rn        = rn;
    val_rm        = rm;
    shift_operand = sop;
    imm_en        = imm;
    s_en          = s;
  endtask

  initial begin
    int busy;
    rst_n = 1'b0; in_valid = 1'b0; exe_cmd = 4'd0; s_en = 1'b0; imm_en = 1'b0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en = 1'b0; branch_en = 1'b0;
    pc = 32'd0; val_rn = 32'd0; val_rm = 32'd0; shift_operand = 12'd0;
    branch_ofs = 24'd0; dest = 4'd0; mem_stall = 1'b0; flush = 1'b0;

    #12 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_res", alu_res, 32'd0);
    chk("rst_store_data", store_data, 32'd0);
    chk("rst_dest_out", 32'(dest_out), 32'd0);
    chk("rst_flags", 32'({mem_r_out, mem_w_out, wb_out, branch_taken}), 32'd0);
    chk("rst_branch_addr", branch_addr, 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_ill_cmd", 32'(ill_cmd), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD with flags: 0x7FFFFFFF + 1 overflows to negative
    wb_en = 1'b1; dest = 4'd3;
    issue(4'b0010, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1);
    tick();
    chk("add_res", alu_res, 32'h8000_0000);
    chk("add_status", 32'(status), 32'b1001);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_dest", 32'(dest_out), 32'd3);
    chk("add_wb_ill", 32'({wb_out, ill_cmd}), 32'b10);

    issue(4'b0001, 32'd0, 32'd0, 12'h2FF, 1'b1, 1'b0);
    tick();
    chk("mov_rot_imm", alu_res, 32'hF000_000F);
    chk("mov_status_kept", 32'(status), 32'b1001);

    issue(4'b0001, 32'd0, 32'h8000_0000, 12'h240, 1'b0, 1'b0);
    tick();
    chk("asr4", alu_res, 32'hF800_0000);
    chk("store_data", store_data, 32'h8000_0000);

    pc = 32'h100; branch_ofs = 24'hFF_FFFF; branch_en = 1'b1;
    issue(4'b0001, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
    tick();
    chk("branch_addr", branch_addr, 32'h0000_00FC);
    chk("branch_taken", 32'(branch_taken), 32'd1);
    branch_en = 1'b0;

    issue(4'b0100, 32'd5, 32'd0, 12'h005, 1'b1, 1'b1);
    tick();
    chk("sub_res", alu_res, 32'd0);
    chk("sub_status", 32'(status), 32'b0110);

    issue(4'b0011, 32'd1, 32'd0, 12'h002, 1'b1, 1'b1);
    tick();
    chk("adc_res", alu_res, 32'd4);
    chk("adc_status", 32'(status), 32'b0000);

    issue(4'b0101, 32'd10, 32'd0, 12'h003, 1'b1, 1'b1);
    tick();
    chk("sbc_res", alu_res, 32'd6);
    chk("sbc_status", 32'(status), 32'b0010);

    issue(4'b0110, 32'h0F0, 32'd0, 12'h00F, 1'b1, 1'b1);
    tick();
    chk("and_res", alu_res, 32'd0);
    chk("and_status_cv_kept", 32'(status), 32'b0110);

    issue(4'b1000, 32'h0FF, 32'd0, 12'h00F, 1'b1, 1'b0);
    tick();
    chk("eor_res", alu_res, 32'h0000_00F0);
    chk("eor_status", 32'(status), 32'b0110);

    issue(4'b1001, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
    tick();
    chk("mvn_res", alu_res, 32'hFFFF_FFFF);

    issue(4'b0111, 32'd0, 32'd1, 12'hF80, 1'b0, 1'b0);
    tick();
    chk("orr_lsl31", alu_res, 32'h8000_0000);

    issue(4'b0001, 32'd0, 32'h8000_0000, 12'hFA0, 1'b0, 1'b0);
    tick();
    chk("lsr31", alu_res, 32'd1);

    issue(4'b0001, 32'd0, 32'h0000_00F1, 12'h260, 1'b0, 1'b0);
    tick();
    chk("ror4", alu_res, 32'h1000_000F);

    // Memory op forces ADD even with an unlisted command; no flag update
    mem_r_en = 1'b1;
    issue(4'b0000, 32'h1000, 32'd0, 12'hFFF, 1'b0, 1'b1);
    tick();
    chk("mem_addr", alu_res, 32'h0000_1FFF);
    chk("mem_r_ill", 32'({mem_r_out, ill_cmd}), 32'b10);
    chk("mem_status", 32'(status), 32'b0110);
    mem_r_en = 1'b0;

    issue(4'b1111, 32'd5, 32'd5, 12'h005, 1'b1, 1'b1);
    tick();
    chk("ill_vld_wb_ill", 32'({out_valid, wb_out, ill_cmd}), 32'b101);
    chk("ill_res", alu_res, 32'd0);
    chk("ill_status", 32'(status), 32'b0110);
    in_valid = 1'b0;
    tick();
    chk("ill_pulse_end", 32'({out_valid, ill_cmd}), 32'b00);

    // Stall holds the output register
    issue(4'b0001, 32'd0, 32'd0, 12'h055, 1'b1, 1'b0);
    tick();
    chk("pre_stall", alu_res, 32'h55);
    issue(4'b0001, 32'd0, 32'd0, 12'h066, 1'b1, 1'b0);
    mem_stall = 1'b1;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("stall_hold", 32'({out_valid, alu_res}), {1'b1, 32'h55} & 32'hFFFF_FFFF | 32'h0);
    chk("stall_hold_res", alu_res, 32'h55);
    mem_stall = 1'b0;
    tick();
    chk("stall_release", alu_res, 32'h66);
    in_valid = 1'b0;

    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;

`ifdef EXE_MUL_EN
    wb_en = 1'b1; dest = 4'd9;
    issue(4'b1010, 32'd7, 32'd6, 12'h000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mul_busy_valid", 32'(out_valid), 32'd0);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      busy++;
      tick();
    end
    chk("mul_busy_cycles", 32'(busy), 32'd32);
    chk("mul_res", alu_res, 32'd42);
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_status", 32'(status), 32'b0010);
    chk("mul_dest_wb", 32'({dest_out, wb_out}), 32'({4'd9, 1'b1}));

    issue(4'b1010, 32'd3, 32'd3, 12'h000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("mflush_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("mflush_valid", 32'(out_valid), 32'd0);
    chk("mflush_status", 32'(status), 32'b0010);
    chk("mflush_in_ready", 32'(in_ready), 32'd1);
    repeat (30) tick();
    chk("mflush_no_result", alu_res, 32'd42);

    issue(4'b1010, 32'd2, 32'd2, 12'h000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mrst_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_status", 32'(status), 32'd0);
    #2 rst_n = 1'b1;
`else
    issue(4'b1010, 32'd7, 32'd6, 12'h000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("nomul_vld_ill", 32'({out_valid, ill_cmd}), 32'b11);
    chk("nomul_res", alu_res, 32'd0);
    chk("nomul_in_ready", 32'(in_ready), 32'd1);
    chk("nomul_status", 32'(status), 32'b0110);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
